// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle CPU control path: opcodes, ALU
// operations, FSM states and instruction field positions.
package cpu_pkg;

    // Instruction opcodes
    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;
    localparam logic [7:0] OP_LWD   = 8'h08;
    localparam logic [7:0] OP_LWI   = 8'h09;
    localparam logic [7:0] OP_SWD   = 8'h0A;
    localparam logic [7:0] OP_SWI   = 8'h0B;

    // ALU operation select
    localparam logic [2:0] ALU_FWD = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    // Instruction field positions
    localparam int unsigned OPCODE_MSB = 32'd31;
    localparam int unsigned OFFSET_LSB = 32'd16;

    // Control FSM states
    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/cpu_control_fsm_pc_next_calc.sv
// Sequential-PC and branch-target adder. Offsets are signed word counts,
// so they are sign-extended and scaled by 4 before being added to PC+4.
// All arithmetic wraps modulo 2^PC_W.
module pc_next_calc #(
    parameter int PC_W     = 32,
    parameter int OFFSET_W = 8
) (
    input  logic [PC_W-1:0]     pc,
    input  logic [OFFSET_W-1:0] offset,
    output logic [PC_W-1:0]     pc_plus4,
    output logic [PC_W-1:0]     branch_target
);

    logic [PC_W-1:0] offset_sext_s;
    logic [PC_W-1:0] offset_bytes_s;

    assign offset_sext_s  = {{(PC_W-OFFSET_W){offset[OFFSET_W-1]}}, offset};
    assign offset_bytes_s = offset_sext_s << 2'd2;
    assign pc_plus4       = pc + PC_W'(3'd4);
    assign branch_target  = pc_plus4 + offset_bytes_s;

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle CPU control path: owns the PC, decodes opcodes into datapath
// controls, and parks in MEM_WAIT while data memory signals BUSYWAIT.
module cpu_control_fsm
    import cpu_pkg::*;
#(
    parameter int PC_W     = 32,
    parameter int OPCODE_W = 8,
    parameter int OFFSET_W = 8
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [31:0]     INSTRUCTION,
    input  logic            ZERO,
    input  logic            BUSYWAIT,
    output logic [PC_W-1:0] PC,
    output logic [2:0]      ALUOP,
    output logic            WRITEENABLE,
    output logic            COMPLEMENT_FLAG,
    output logic            IMMEDIATE_FLAG,
    output logic            MEM_READ,
    output logic            MEM_WRITE,
    output logic            REG_SRC_MEM,
    output logic            ILLEGAL
);

    state_e              state_r, state_next_s;
    logic [PC_W-1:0]     pc_r, pc_next_s, pc_plus4_s, branch_target_s;
    logic                illegal_r, illegal_set_s;
    logic                mem_is_load_r, mem_imm_r;
    logic                mem_latch_s, latch_load_s, latch_imm_s;
    logic [OPCODE_W-1:0] opcode_s;
    logic [OFFSET_W-1:0] offset_s;
    logic [2:0]          aluop_s;
    logic                we_s, comp_s, imm_s, mem_read_s, mem_write_s, reg_src_mem_s;
    logic                unused_s;

    assign opcode_s = INSTRUCTION[OPCODE_MSB -: OPCODE_W];
    assign offset_s = INSTRUCTION[OFFSET_LSB +: OFFSET_W];
    // Register-index / immediate fields belong to the datapath, not control.
    assign unused_s = ^INSTRUCTION[OFFSET_LSB-1:0];

    pc_next_calc #(
        .PC_W     (PC_W),
        .OFFSET_W (OFFSET_W)
    ) u_pc_next_calc (
        .pc            (pc_r),
        .offset        (offset_s),
        .pc_plus4      (pc_plus4_s),
        .branch_target (branch_target_s)
    );

    // Decode and next-state: controls default to 0 and stay 0 under RESET.
    always_comb begin
        aluop_s       = ALU_FWD;
        we_s          = 1'b0;
        comp_s        = 1'b0;
        imm_s         = 1'b0;
        mem_read_s    = 1'b0;
        mem_write_s   = 1'b0;
        reg_src_mem_s = 1'b0;
        state_next_s  = state_r;
        pc_next_s     = pc_plus4_s;
        illegal_set_s = 1'b0;
        mem_latch_s   = 1'b0;
        latch_load_s  = 1'b0;
        latch_imm_s   = 1'b0;
        if (RESET) begin
            state_next_s = RUN;
            pc_next_s    = {PC_W{1'b0}};
        end else begin
            case (state_r)
                RUN: begin
                    case (opcode_s)
                        OPCODE_W'(OP_LOADI): begin
                            imm_s = 1'b1;
                            we_s  = 1'b1;
                        end
                        OPCODE_W'(OP_MOV): begin
                            we_s = 1'b1;
                        end
                        OPCODE_W'(OP_ADD): begin
                            aluop_s = ALU_ADD;
                            we_s    = 1'b1;
                        end
                        OPCODE_W'(OP_SUB): begin
                            aluop_s = ALU_ADD;
                            comp_s  = 1'b1;
                            we_s    = 1'b1;
                        end
                        OPCODE_W'(OP_AND): begin
                            aluop_s = ALU_AND;
                            we_s    = 1'b1;
                        end
                        OPCODE_W'(OP_OR): begin
                            aluop_s = ALU_OR;
                            we_s    = 1'b1;
                        end
                        OPCODE_W'(OP_J): begin
                            pc_next_s = branch_target_s;
                        end
                        OPCODE_W'(OP_BEQ): begin
                            aluop_s = ALU_ADD;
                            comp_s  = 1'b1;
                            if (ZERO) begin
                                pc_next_s = branch_target_s;
                            end else begin
                                pc_next_s = pc_plus4_s;
                            end
                        end
                        OPCODE_W'(OP_LWD), OPCODE_W'(OP_LWI): begin
                            imm_s        = (opcode_s == OPCODE_W'(OP_LWI));
                            mem_read_s   = 1'b1;
                            pc_next_s    = pc_r;
                            state_next_s = MEM_WAIT;
                            mem_latch_s  = 1'b1;
                            latch_load_s = 1'b1;
                            latch_imm_s  = imm_s;
                        end
                        OPCODE_W'(OP_SWD), OPCODE_W'(OP_SWI): begin
                            imm_s        = (opcode_s == OPCODE_W'(OP_SWI));
                            mem_write_s  = 1'b1;
                            pc_next_s    = pc_r;
                            state_next_s = MEM_WAIT;
                            mem_latch_s  = 1'b1;
                            latch_load_s = 1'b0;
                            latch_imm_s  = imm_s;
                        end
                        default: begin
                            illegal_set_s = 1'b1;
                        end
                    endcase
                end
                MEM_WAIT: begin
                    // Hold the request and address settings captured on entry.
                    imm_s       = mem_imm_r;
                    mem_read_s  = mem_is_load_r;
                    mem_write_s = ~mem_is_load_r;
                    if (BUSYWAIT) begin
                        pc_next_s = pc_r;
                    end else begin
                        we_s          = mem_is_load_r;
                        reg_src_mem_s = mem_is_load_r;
                        pc_next_s     = pc_plus4_s;
                        state_next_s  = RUN;
                    end
                end
                default: begin
                    state_next_s = RUN;
                end
            endcase
        end
    end

    // State, PC, sticky illegal flag and memory-op class registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r       <= RUN;
            pc_r          <= {PC_W{1'b0}};
            illegal_r     <= 1'b0;
            mem_is_load_r <= 1'b0;
            mem_imm_r     <= 1'b0;
        end else begin
            state_r <= state_next_s;
            pc_r    <= pc_next_s;
            if (illegal_set_s) begin
                illegal_r <= 1'b1;
            end
            if (mem_latch_s) begin
                mem_is_load_r <= latch_load_s;
                mem_imm_r     <= latch_imm_s;
            end
        end
    end

    assign PC              = pc_r;
    assign ALUOP           = aluop_s;
    assign WRITEENABLE     = we_s;
    assign COMPLEMENT_FLAG = comp_s;
    assign IMMEDIATE_FLAG  = imm_s;
    assign MEM_READ        = mem_read_s;
    assign MEM_WRITE       = mem_write_s;
    assign REG_SRC_MEM     = reg_src_mem_s;
    assign ILLEGAL         = illegal_r;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm: each step drives one cycle of inputs,
// pushes the expected PC/controls/ILLEGAL to a scoreboard and compares them
// with the DUT outputs 1 time unit after the falling edge.
module tb_cpu_control_fsm;

    logic        CLK;
    logic        RESET;
    logic [31:0] INSTRUCTION;
    logic        ZERO;
    logic        BUSYWAIT;
    logic [31:0] PC;
    logic [2:0]  ALUOP;
    logic        WRITEENABLE;
    logic        COMPLEMENT_FLAG;
    logic        IMMEDIATE_FLAG;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic        REG_SRC_MEM;
    logic        ILLEGAL;

    int n_assert;
    int n_fail;

    // Control vector layout: {ALUOP[2:0], WE, COMP, IMM, MEM_READ, MEM_WRITE, REG_SRC_MEM}
    localparam logic [8:0] C_NONE = 9'b000_000000;
    localparam logic [8:0] C_ADD  = 9'b001_100000;
    localparam logic [8:0] C_SUB  = 9'b001_110000;
    localparam logic [8:0] C_LDI  = 9'b000_101000;
    localparam logic [8:0] C_MOV  = 9'b000_100000;
    localparam logic [8:0] C_AND  = 9'b010_100000;
    localparam logic [8:0] C_OR   = 9'b011_100000;
    localparam logic [8:0] C_BEQ  = 9'b001_010000;
    localparam logic [8:0] C_LRD  = 9'b000_000100;
    localparam logic [8:0] C_LFIN = 9'b000_100101;
    localparam logic [8:0] C_SWI  = 9'b000_001010;
    localparam logic [8:0] C_SWD  = 9'b000_000010;

    localparam logic [7:0] O_LOADI = 8'h00;
    localparam logic [7:0] O_MOV   = 8'h01;
    localparam logic [7:0] O_ADD   = 8'h02;
    localparam logic [7:0] O_SUB   = 8'h03;
    localparam logic [7:0] O_AND   = 8'h04;
    localparam logic [7:0] O_OR    = 8'h05;
    localparam logic [7:0] O_J     = 8'h06;
    localparam logic [7:0] O_BEQ   = 8'h07;
    localparam logic [7:0] O_LWD   = 8'h08;
    localparam logic [7:0] O_SWD   = 8'h0A;
    localparam logic [7:0] O_SWI   = 8'h0B;
    localparam logic [7:0] O_BAD   = 8'hFF;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [8:0]  ctl;
        logic        ill;
    } exp_t;

    exp_t sb[$];

    cpu_control_fsm #(
        .PC_W     (32),
        .OPCODE_W (8),
        .OFFSET_W (8)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .INSTRUCTION     (INSTRUCTION),
        .ZERO            (ZERO),
        .BUSYWAIT        (BUSYWAIT),
        .PC              (PC),
        .ALUOP           (ALUOP),
        .WRITEENABLE     (WRITEENABLE),
        .COMPLEMENT_FLAG (COMPLEMENT_FLAG),
        .IMMEDIATE_FLAG  (IMMEDIATE_FLAG),
        .MEM_READ        (MEM_READ),
        .MEM_WRITE       (MEM_WRITE),
        .REG_SRC_MEM     (REG_SRC_MEM),
        .ILLEGAL         (ILLEGAL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_one(input string tag, input string field,
                             input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, expv);
        end
    endtask

    task automatic compare_front();
        exp_t e;
        e = sb.pop_front();
        check_one(e.tag, "pc", PC, e.pc);
        check_one(e.tag, "ctl",
                  {23'd0, ALUOP, WRITEENABLE, COMPLEMENT_FLAG, IMMEDIATE_FLAG,
                   MEM_READ, MEM_WRITE, REG_SRC_MEM},
                  {23'd0, e.ctl});
        check_one(e.tag, "illegal", {31'd0, ILLEGAL}, {31'd0, e.ill});
    endtask

    task automatic step(input string tag, input logic rst, input logic [7:0] op,
                        input logic [7:0] off, input logic zero, input logic busy,
                        input logic [31:0] e_pc, input logic [8:0] e_ctl,
                        input logic e_ill);
        exp_t e;
        @(negedge CLK);
        RESET       = rst;
        INSTRUCTION = {op, off, 16'h1234};
        ZERO        = zero;
        BUSYWAIT    = busy;
        e.tag = tag;
        e.pc  = e_pc;
        e.ctl = e_ctl;
        e.ill = e_ill;
        sb.push_back(e);
        #1;
        compare_front();
    endtask

    initial begin
        n_assert    = 0;
        n_fail      = 0;
        RESET       = 1'b1;
        INSTRUCTION = {O_ADD, 24'h000000};
        ZERO        = 1'b0;
        BUSYWAIT    = 1'b0;

        // Reset held two cycles with add on the bus
        step("rst0",  1'b1, O_ADD,   8'h00, 1'b0, 1'b0, 32'h0000_0000, C_NONE, 1'b0);
        step("rst1",  1'b1, O_ADD,   8'h00, 1'b0, 1'b0, 32'h0000_0000, C_NONE, 1'b0);
        // Straight-line ALU ops
        step("add0",  1'b0, O_ADD,   8'h00, 1'b0, 1'b0, 32'h0000_0000, C_ADD,  1'b0);
        step("add1",  1'b0, O_ADD,   8'h00, 1'b0, 1'b0, 32'h0000_0004, C_ADD,  1'b0);
        step("add2",  1'b0, O_ADD,   8'h00, 1'b0, 1'b0, 32'h0000_0008, C_ADD,  1'b0);
        step("sub",   1'b0, O_SUB,   8'h00, 1'b0, 1'b0, 32'h0000_000C, C_SUB,  1'b0);
        step("loadi", 1'b0, O_LOADI, 8'h00, 1'b0, 1'b0, 32'h0000_0010, C_LDI,  1'b0);
        step("mov",   1'b0, O_MOV,   8'h00, 1'b0, 1'b0, 32'h0000_0014, C_MOV,  1'b0);
        step("and",   1'b0, O_AND,   8'h00, 1'b0, 1'b0, 32'h0000_0018, C_AND,  1'b0);
        step("or",    1'b0, O_OR,    8'h00, 1'b0, 1'b0, 32'h0000_001C, C_OR,   1'b0);
        // Jumps and branches (0x24 - 20 = 0x10, etc.)
        step("jback", 1'b0, O_J,     8'hFB, 1'b0, 1'b0, 32'h0000_0020, C_NONE, 1'b0);
        step("beqT",  1'b0, O_BEQ,   8'hFE, 1'b1, 1'b0, 32'h0000_0010, C_BEQ,  1'b0);
        step("j0",    1'b0, O_J,     8'h00, 1'b0, 1'b0, 32'h0000_000C, C_NONE, 1'b0);
        step("beqN",  1'b0, O_BEQ,   8'hFE, 1'b0, 1'b0, 32'h0000_0010, C_BEQ,  1'b0);
        step("jm2",   1'b0, O_J,     8'hFE, 1'b0, 1'b0, 32'h0000_0014, C_NONE, 1'b0);
        step("jp2",   1'b0, O_J,     8'h02, 1'b0, 1'b0, 32'h0000_0010, C_NONE, 1'b0);
        step("jm6",   1'b0, O_J,     8'hFA, 1'b0, 1'b0, 32'h0000_001C, C_NONE, 1'b0);
        // lwd at PC=8: BUSYWAIT high in request cycle and two wait cycles
        step("lwd0",  1'b0, O_LWD,   8'h00, 1'b0, 1'b1, 32'h0000_0008, C_LRD,  1'b0);
        step("lwd1",  1'b0, O_LWD,   8'h00, 1'b0, 1'b1, 32'h0000_0008, C_LRD,  1'b0);
        step("lwd2",  1'b0, O_LWD,   8'h00, 1'b0, 1'b1, 32'h0000_0008, C_LRD,  1'b0);
        step("lwd3",  1'b0, O_LWD,   8'h00, 1'b0, 1'b0, 32'h0000_0008, C_LFIN, 1'b0);
        // swi stalled, then reset arrives mid-wait
        step("swi0",  1'b0, O_SWI,   8'h00, 1'b0, 1'b1, 32'h0000_000C, C_SWI,  1'b0);
        step("swi1",  1'b0, O_SWI,   8'h00, 1'b0, 1'b1, 32'h0000_000C, C_SWI,  1'b0);
        step("swiR",  1'b1, O_SWI,   8'h00, 1'b0, 1'b1, 32'h0000_000C, C_NONE, 1'b0);
        step("postR", 1'b0, O_ADD,   8'h00, 1'b0, 1'b1, 32'h0000_0000, C_ADD,  1'b0);
        // Undefined opcode sets sticky ILLEGAL
        step("bad",   1'b0, O_BAD,   8'h00, 1'b0, 1'b0, 32'h0000_0004, C_NONE, 1'b0);
        step("ill1",  1'b0, O_ADD,   8'h00, 1'b0, 1'b0, 32'h0000_0008, C_ADD,  1'b1);
        step("ill2",  1'b0, O_MOV,   8'h00, 1'b0, 1'b0, 32'h0000_000C, C_MOV,  1'b1);
        step("illR0", 1'b1, O_ADD,   8'h00, 1'b0, 1'b0, 32'h0000_0010, C_NONE, 1'b1);
        step("illR1", 1'b1, O_ADD,   8'h00, 1'b0, 1'b0, 32'h0000_0000, C_NONE, 1'b0);
        // PC wrap: 0 + 4 - 8 = 0xFFFFFFFC, then add wraps to 0
        step("jneg",  1'b0, O_J,     8'hFE, 1'b0, 1'b0, 32'h0000_0000, C_NONE, 1'b0);
        step("wrap",  1'b0, O_ADD,   8'h00, 1'b0, 1'b0, 32'hFFFF_FFFC, C_ADD,  1'b0);
        // swd with no stall: two-cycle minimum, never WE with MEM_WRITE
        step("swd0",  1'b0, O_SWD,   8'h00, 1'b0, 1'b0, 32'h0000_0000, C_SWD,  1'b0);
        step("swd1",  1'b0, O_SWD,   8'h00, 1'b0, 1'b0, 32'h0000_0000, C_SWD,  1'b0);
        step("swd2",  1'b0, O_ADD,   8'h00, 1'b0, 1'b0, 32'h0000_0004, C_ADD,  1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
